// File: rtl/reg_ctrl_pkg.sv
// Shared types for the register-bank controller: accumulate opcodes and FSM states.
package reg_ctrl_pkg;

  localparam int FUNC_W = 2;

  typedef enum logic [FUNC_W-1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    XOR = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    RMW  = 2'b10
  } state_e;

endpackage

// File: rtl/reg_ctrl_alu.sv
// Combinational accumulate ALU: unsigned add/sub (wrapping or saturating), bitwise and/xor.
module reg_ctrl_alu
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SAT    = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  func_e             func,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // One extra bit on add/sub exposes carry-out and borrow for the clamp decision.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    y    = '0;
    case (func)
      ADD: y = ((SAT != 0) && sum[DATA_W])  ? '1 : sum[DATA_W-1:0];
      SUB: y = ((SAT != 0) && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
      AND: y = a & b;
      XOR: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register-bank controller: zero-wait plain writes, 1-cycle reads and read-modify-write
// accumulates over a flat DEPTH-entry bank, with out-of-range detection.
//
// Handshake: a request is taken at a rising edge where sel && ready; ready is high only
// while idle, and sel held through a busy cycle is not re-taken until ready returns.
module reg_bank_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter int              DEPTH     = 8,
  parameter int              ADDR_W    = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int              SAT       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic              acc,
  input  logic [FUNC_W-1:0] func,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output state_e            state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  func_e               func_q, func_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   bank_q [DEPTH];
  logic [DATA_W-1:0]   bank_d [DEPTH];
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                in_range;
  logic [DATA_W-1:0]   alu_y;

  reg_ctrl_alu #(
    .DATA_W (DATA_W),
    .SAT    (SAT)
  ) u_alu (
    .a    (bank_q[addr_q]),
    .b    (wdata_q),
    .func (func_q),
    .y    (alu_y)
  );

  // Next-state logic: accept in IDLE, finish reads and accumulates one cycle later.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    func_d   = func_q;
    wdata_d  = wdata_q;
    bank_d   = bank_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    in_range = ({1'b0, addr} < DEPTH_C);
    unique case (state_q)
      IDLE: begin
        if (sel) begin
          addr_d  = addr;
          func_d  = func_e'(func);
          wdata_d = wdata;
          if (!in_range) begin
            // Rejected access: flag it, never touch the bank, stay idle.
            err_d = 1'b1;
            if (!wr) rdata_d = '0;
          end else if (!wr) begin
            state_d = RD;
          end else if (acc) begin
            state_d = RMW;
          end else begin
            bank_d[addr] = wdata;
          end
        end
      end
      RD: begin
        rdata_d = bank_q[addr_q];
        state_d = IDLE;
      end
      RMW: begin
        bank_d[addr_q] = alu_y;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any in-flight read or accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      func_q  <= ADD;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= RESET_VAL;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      func_q  <= func_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      bank_q  <= bank_d;
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl: three instances (wrapping, saturating, DEPTH=6) share one
// request bus and are each compared against a per-instance arithmetic reference model.
module tb_reg_bank_ctrl;
  import reg_ctrl_pkg::*;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        sel, wr, acc;
  logic [1:0]  func;
  logic [2:0]  addr;
  logic [15:0] wdata;

  logic [15:0] rdata_w [N];
  logic        ready_w [N];
  logic        err_w   [N];
  state_e      st_w    [N];

  reg_bank_ctrl #(.DATA_W(16), .DEPTH(8), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .acc(acc), .func(func),
    .wdata(wdata), .rdata(rdata_w[0]), .ready(ready_w[0]), .err(err_w[0]), .state_dbg(st_w[0]));
  reg_bank_ctrl #(.DATA_W(16), .DEPTH(8), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .acc(acc), .func(func),
    .wdata(wdata), .rdata(rdata_w[1]), .ready(ready_w[1]), .err(err_w[1]), .state_dbg(st_w[1]));
  reg_bank_ctrl #(.DATA_W(16), .DEPTH(6), .SAT(0)) u_d6 (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .acc(acc), .func(func),
    .wdata(wdata), .rdata(rdata_w[2]), .ready(ready_w[2]), .err(err_w[2]), .state_dbg(st_w[2]));

  // ---------------- reference model ----------------
  int          depth_m [N] = '{8, 8, 6};
  int          sat_m   [N] = '{0, 1, 0};
  int          m_bank  [N][8];
  int          m_rdata [N];
  logic [15:0] exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  function automatic int ref_alu(input int a, input int b, input int f, input int s);
    int r;
    r = 0;
    case (f)
      0: begin
        r = a + b;
        if (r > 65535) r = (s != 0) ? 65535 : r - 65536;
      end
      1: begin
        r = a - b;
        if (r < 0) r = (s != 0) ? 0 : r + 65536;
      end
      2: r = a & b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_rdata[i] = 0;
      for (int k = 0; k < 8; k++) m_bank[i][k] = 0;
    end
    exp_q.delete();
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_ready[%0d]", tag, i), ready_w[i], 1);
      check($sformatf("%s_err[%0d]", tag, i), err_w[i], 0);
      check($sformatf("%s_rdata[%0d]", tag, i), rdata_w[i], m_rdata[i][15:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a rising edge with all instances idle.
  task automatic do_op(input bit w, input bit a, input int f, input int ad, input int wd);
    bit oor;
    sel = 1'b1; wr = w; acc = a; func = f[1:0]; addr = ad[2:0]; wdata = wd[15:0];
    @(posedge clk); #1;
    // Scramble the bus so anything not latched at accept shows up.
    sel = 1'b0; wr = 1'($urandom); acc = 1'($urandom); func = 2'($urandom);
    addr = 3'($urandom); wdata = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      oor = (ad >= depth_m[i]);
      if (oor) begin
        if (!w) m_rdata[i] = 0;
      end else if (w && !a) begin
        m_bank[i][ad] = wd & 16'hFFFF;
      end else if (!w) begin
        exp_q.push_back(m_bank[i][ad][15:0]);
      end
      check($sformatf("t0_err[%0d]", i), err_w[i], oor);
      check($sformatf("t0_ready[%0d]", i), ready_w[i], oor || (w && !a));
      check($sformatf("t0_rdata[%0d]", i), rdata_w[i], m_rdata[i][15:0]);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      oor = (ad >= depth_m[i]);
      if (!oor) begin
        if (!w) m_rdata[i] = int'(exp_q.pop_front());
        else if (a) m_bank[i][ad] = ref_alu(m_bank[i][ad], wd & 16'hFFFF, f, sat_m[i]);
      end
    end
    check_idle("t1");
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    sel = 1'b1; wr = 1'($urandom); acc = 1'($urandom); addr = 3'($urandom);
    wdata = 16'($urandom); func = 2'($urandom);
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      check_idle("rst");
    end
    rst = 1'b0; sel = 1'b0;
    @(posedge clk); #1;
    check_idle("post_rst");
  endtask

  function automatic int pick_data();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 16'hFFFF;
      2: return $urandom_range(1, 3);
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; sel = 1'b0; wr = 1'b0; acc = 1'b0; func = '0; addr = '0; wdata = '0;

    // 1: reset, then every address reads back the reset value
    do_reset(3);
    for (int k = 0; k < 8; k++) do_op(0, 0, 0, k, 0);

    // 2: write/read
    do_op(1, 0, 0, 3, 16'hA5A5);
    do_op(0, 0, 0, 3, 0);
    check("wr_rd_a5a5", rdata_w[0], 16'hA5A5);
    do_op(0, 0, 0, 2, 0);
    check("rd_addr2_zero", rdata_w[0], 16'h0000);

    // 3: accumulate chain on reg5
    do_op(1, 0, 0, 5, 16'hFFF0);
    do_op(1, 1, 0, 5, 16'h0020);
    do_op(0, 0, 0, 5, 0);
    check("acc_add_wrap", rdata_w[0], 16'h0010);
    check("acc_add_sat", rdata_w[1], 16'hFFFF);
    do_op(1, 1, 1, 5, 16'h0011);
    do_op(0, 0, 0, 5, 0);
    check("acc_sub_wrap", rdata_w[0], 16'hFFFF);
    do_op(1, 1, 2, 5, 16'h0F0F);
    do_op(1, 1, 3, 5, 16'h00FF);
    do_op(0, 0, 0, 5, 0);
    check("acc_and_xor", rdata_w[0], 16'h0FF0);

    // 4: saturation on reg1
    do_op(1, 0, 0, 1, 16'hFFF0);
    do_op(1, 1, 0, 1, 16'h0020);
    do_op(1, 1, 1, 1, 16'hFFFF);
    do_op(1, 1, 1, 1, 16'h0001);
    do_op(0, 0, 0, 1, 0);
    check("sat_sub_floor", rdata_w[1], 16'h0000);
    check("wrap_sub_chain", rdata_w[0], 16'h0010);

    // 5: out-of-range on the DEPTH=6 instance
    do_op(1, 0, 0, 6, 16'h1234);
    do_op(0, 0, 0, 7, 0);
    check("oor_rd_zero", rdata_w[2], 16'h0000);
    for (int k = 0; k < 6; k++) do_op(0, 0, 0, k, 0);

    // back-to-back plain writes, one per cycle
    sel = 1'b1; wr = 1'b1; acc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int d;
      d = pick_data();
      addr = 3'(k); wdata = d[15:0];
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        m_bank[i][k] = d;
        check($sformatf("b2b_ready[%0d]", i), ready_w[i], 1);
      end
    end
    sel = 1'b0;
    for (int k = 0; k < 4; k++) do_op(0, 0, 0, k, 0);

    // 6a: reset in the RMW cycle aborts the accumulate
    do_op(1, 0, 0, 0, 7);
    sel = 1'b1; wr = 1'b1; acc = 1'b1; func = 2'd0; addr = 3'd0; wdata = 16'd1;
    @(posedge clk); #1;
    sel = 1'b0;
    check("abort_busy", ready_w[0], 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("abort");
    do_op(0, 0, 0, 0, 0);
    do_op(1, 0, 0, 4, 16'h0055);
    do_op(0, 0, 0, 0, 0);
    check("abort_reg0", rdata_w[0], 16'h0000);

    // 6b: sel held across busy cycles: one accumulate per ready window
    do_op(1, 0, 0, 2, 0);
    sel = 1'b1; wr = 1'b1; acc = 1'b1; func = 2'd0; addr = 3'd2; wdata = 16'd1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold_acc_ready%0d", c), ready_w[0], c % 2);
    end
    sel = 1'b0;
    for (int i = 0; i < N; i++) m_bank[i][2] = m_bank[i][2] + 2;
    do_op(0, 0, 0, 2, 0);
    check("hold_acc_count", rdata_w[0], 16'h0002);

    // held read
    do_op(1, 0, 0, 4, 16'h3C3C);
    sel = 1'b1; wr = 1'b0; acc = 1'b0; addr = 3'd4;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c % 2 == 1) for (int i = 0; i < N; i++) m_rdata[i] = m_bank[i][4];
      check($sformatf("hold_rd_ready%0d", c), ready_w[0], c % 2);
      check($sformatf("hold_rd_rdata%0d", c), rdata_w[0], m_rdata[0][15:0]);
    end
    sel = 1'b0;
    @(posedge clk); #1;
    check_idle("hold_rd_end");

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      if (n == 150) do_reset($urandom_range(1, 3));
      do_op(1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 7), pick_data());
    end
    for (int k = 0; k < 8; k++) do_op(0, 0, 0, k, 0);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog: the sequence is bounded, this only guards against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Parametrised register-bank controller, the successor to the single-bank `reg_ctrl`. It serves a `DEPTH`-entry bank of `DATA_W`-bit registers behind the same `sel`/`wr`/`acc`/`func`/`ready` handshake. It adds read-modify-write accumulate operations, optional saturating arithmetic and out-of-range address detection. It sits between a bus master (the testbench driver, later a CPU-side bridge) and the design's control registers.

## Interface

- `DATA_W`, 16: register and data-bus width, at least 2.
- `DEPTH`, 8: number of registers, at least 2, not required to be a power of two.
- `ADDR_W`, `$clog2(DEPTH)`: address width.
- `RESET_VAL`, 0: value loaded into every register on reset.
- `SAT`, 0: 0 selects wrapping add/sub, 1 selects saturating (unsigned) add/sub.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sel`  in  1  request valid.
- `wr`  in  1  1 = write/accumulate, 0 = read.
- `addr`  in  `ADDR_W`  register index.
- `acc`  in  1  on a write, 1 = accumulate (read-modify-write), 0 = plain store.
- `func`  in  2  accumulate op: 00 add, 01 sub, 10 and, 11 xor.
- `wdata`  in  `DATA_W`  write operand.
- `rdata`  out  `DATA_W`  read data, registered.
- `ready`  out  1  controller idle; a request is accepted when `sel && ready` at a rising edge.
- `err`  out  1  one-cycle pulse for an out-of-range access.

## Operation

- **States:** IDLE, RD, RMW.
  - `ready` is 1 only in IDLE.
  - Inputs are ignored outside IDLE. `addr`, `func` and `wdata` are latched at accept.
- **Plain write** (`wr=1`, `acc=0`): the register updates at the accept edge. State stays IDLE. Zero wait states.
- **Read** (`wr=0`): IDLE→RD at accept.
  - The next edge loads `rdata` with `bank[addr]` and returns to IDLE.
  - `rdata` holds its value until the next read completes.
- **Accumulate** (`wr=1`, `acc=1`): IDLE→RMW at accept.
  - The next edge writes `bank[addr] <= bank[addr] op wdata` and returns to IDLE.
  - `rdata` is not changed.
- **Arithmetic:** unsigned, `DATA_W` bits.
  - `SAT=0`: add and sub wrap modulo 2^`DATA_W`.
  - `SAT=1`: add clamps at all-ones and sub clamps at 0.
  - `and` and `xor` are bitwise and unaffected by `SAT`.
- **Out of range** (`addr >= DEPTH`, accepted request):
  - No register is modified. State stays IDLE.
  - `err` pulses high for the cycle following the accept edge.
  - For a read, `rdata` is loaded with 0 at the same edge.
- **Reset:** while `rst` is high, and at the first edge after it is released:
  - state is IDLE, every register holds `RESET_VAL`;
  - `rdata` is 0, `err` is 0, `ready` is 1;
  - `sel` is ignored while `rst` is high.
- **Reset during RD or RMW:** the operation is aborted and no write occurs.

## Timing

- Accept edge T0 is the edge where `sel && ready`.
- Plain write: the register holds the new value from T0. Back-to-back writes are possible every cycle.
- Read: `ready` is 0 in cycle T0→T1. `rdata` is valid and `ready` is 1 from T1. Throughput is one read per 2 cycles.
- Accumulate: `ready` is 0 in T0→T1. The updated register is visible from T1. A read issued at T1 returns the updated value at T2.
- Out-of-range: `err` is 1 in cycle T0→T1. `ready` stays 1.
- Holding `sel` high across a busy cycle does not re-issue the request. The request is accepted again only at the next edge where `ready` is 1.

## Structure

- **`reg_ctrl_pkg`:**
  - `func_e` enum (ADD, SUB, AND, XOR);
  - `state_e` enum (IDLE, RD, RMW);
  - `FUNC_W = 2` constant.
- **`reg_ctrl_alu`:** combinational sub-module, parametrised by `DATA_W` and `SAT`.
  - Inputs: `a`, `b`, `func_e`. Output: `y`.
  - Instantiated once in `reg_bank_ctrl` and testable standalone.
- The bank is a flat register array of `DEPTH` entries. No RAM macro.

## Test plan

1. **Reset:** reset, then read all 8 addresses → every `rdata` = `RESET_VAL` (0). Across the reset cycles `ready`=1, `err`=0, `rdata`=0.
2. **Write/read:** write 0xA5A5 to addr 3, then read addr 3 → `rdata`=0xA5A5 one cycle after accept, with `ready` low for exactly 1 cycle. Addr 2 still reads 0.
3. **Accumulate, `SAT=0`:**
   - reg5=0xFFF0; add 0x0020 → 0x0010;
   - sub 0x0011 → 0xFFFF;
   - and 0x0F0F → 0x0F0F;
   - xor 0x00FF → 0x0FF0.
4. **Accumulate, `SAT=1`:** reg1=0xFFF0; add 0x0020 → 0xFFFF; then sub 0xFFFF and sub 1 → 0x0000.
5. **Out-of-range, `DEPTH=6`:** write 0x1234 to addr 6, then read addr 7 → `err` pulses once each. Read `rdata`=0. Registers 0–5 unchanged.
6. **Abort and busy handling:**
   - assert `rst` in the RMW cycle of an add on reg0 holding 7 → reg0=`RESET_VAL` afterwards, not incremented;
   - hold `sel` high through a read → exactly one read accepted per `ready` window.
